// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding selects, load/branch/MDU
// stalls, stage-M exception flush, MDU busy tracking and saturating stall counters.
module hazard_scoreboard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [1:0]        RsUsageD,
  input  logic [1:0]        RtUsageD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] RtM,
  input  logic [REG_AW-1:0] RegAddrE,
  input  logic [REG_AW-1:0] RegAddrM,
  input  logic [REG_AW-1:0] RegAddrW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic              MDUUseD,
  input  logic              StartMDUE,
  input  logic              IsDivE,
  input  logic              ExcReqM,
  input  logic              ClearPerf,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              FlushD,
  output logic              FlushM,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardM,
  output logic              MDUBusy,
  output logic [PERF_W-1:0] DataStallCnt,
  output logic [PERF_W-1:0] MDUStallCnt
);

  localparam int BW = $clog2(DIV_CYCLES + 1);

  logic [BW-1:0] busy_cnt;
  logic          data_stall;
  logic          mdu_stall;

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
    if (src != '0 && src == RegAddrM && RegWriteM)      return 2'd1;
    else if (src != '0 && src == RegAddrW && RegWriteW) return 2'd2;
    else                                                return 2'd0;
  endfunction

  // usage 1 only waits on a load in E; usage 2 also waits on any E write or a load in M
  function automatic logic src_stall(input logic [REG_AW-1:0] src, input logic [1:0] usage);
    logic hit_e, hit_m;
    hit_e = (src != '0) && (src == RegAddrE) && RegWriteE;
    hit_m = (src != '0) && (src == RegAddrM) && RegWriteM && MemToRegM;
    case (usage)
      2'd1:    return hit_e && MemToRegE;
      2'd2:    return hit_e || hit_m;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    ForwardAE = fwd_e(RsE);
    ForwardBE = fwd_e(RtE);
    ForwardAD = (RsD != '0) && (RsD == RegAddrM) && RegWriteM;
    ForwardBD = (RtD != '0) && (RtD == RegAddrM) && RegWriteM;
    ForwardM  = (RtM != '0) && (RtM == RegAddrW) && RegWriteW;
  end

  assign MDUBusy    = (busy_cnt != '0);
  assign data_stall = src_stall(RsD, RsUsageD) || src_stall(RtD, RtUsageD);
  assign mdu_stall  = MDUUseD && (StartMDUE || MDUBusy);
  assign StallD     = (data_stall || mdu_stall) && !ExcReqM;
  assign StallF     = StallD;
  assign FlushE     = StallD || ExcReqM;
  assign FlushD     = ExcReqM;
  assign FlushM     = ExcReqM;

  // a start squashed by the exception never loads; a running op keeps counting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
    end else if (StartMDUE && !ExcReqM) begin
      busy_cnt <= IsDivE ? BW'(DIV_CYCLES) : BW'(MULT_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DataStallCnt <= '0;
      MDUStallCnt  <= '0;
    end else if (ClearPerf) begin
      DataStallCnt <= '0;
      MDUStallCnt  <= '0;
    end else begin
      if (data_stall && StallD && !(&DataStallCnt)) DataStallCnt <= DataStallCnt + 1'b1;
      if (mdu_stall && StallD && !(&MDUStallCnt))   MDUStallCnt  <= MDUStallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: forwarding, stalls, MDU busy, flush,
// counter saturation/clear and asynchronous reset.
module tb_hazard_scoreboard_ctrl;

  localparam int REG_AW = 5;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE, RtM, RegAddrE, RegAddrM, RegAddrW;
  logic [1:0]        RsUsageD, RtUsageD;
  logic              RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
  logic              MDUUseD, StartMDUE, IsDivE, ExcReqM, ClearPerf;
  logic              StallF, StallD, FlushE, FlushD, FlushM, ForwardAD, ForwardBD, ForwardM, MDUBusy;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [PERF_W-1:0] DataStallCnt, MDUStallCnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard_ctrl #(.REG_AW(REG_AW), .MULT_CYCLES(5), .DIV_CYCLES(10), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsUsageD(RsUsageD), .RtUsageD(RtUsageD),
    .RsE(RsE), .RtE(RtE), .RtM(RtM),
    .RegAddrE(RegAddrE), .RegAddrM(RegAddrM), .RegAddrW(RegAddrW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
    .MDUUseD(MDUUseD), .StartMDUE(StartMDUE), .IsDivE(IsDivE),
    .ExcReqM(ExcReqM), .ClearPerf(ClearPerf),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD), .FlushM(FlushM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardM(ForwardM), .MDUBusy(MDUBusy),
    .DataStallCnt(DataStallCnt), .MDUStallCnt(MDUStallCnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0; RtM = '0;
    RegAddrE = '0; RegAddrM = '0; RegAddrW = '0;
    RsUsageD = 2'd0; RtUsageD = 2'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemToRegE = 1'b0; MemToRegM = 1'b0;
    MDUUseD = 1'b0; StartMDUE = 1'b0; IsDivE = 1'b0; ExcReqM = 1'b0; ClearPerf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_use_rs8();
    RegAddrE = 5'd8; RegWriteE = 1'b1; MemToRegE = 1'b1;
    RsD = 5'd8; RsUsageD = 2'd1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check("rst_busy", MDUBusy, 0);
    check("rst_dcnt", DataStallCnt, 0);
    check("rst_mcnt", MDUStallCnt, 0);
    check("rst_stall", StallD, 0);
    check("rst_flushd", FlushD, 0);
    reset = 1'b1;
    step();

    // load-use
    load_use_rs8(); settle();
    check("lu_stallf", StallF, 1);
    check("lu_stalld", StallD, 1);
    check("lu_flushe", FlushE, 1);
    check("lu_flushm", FlushM, 0);
    step();
    idle();
    RegAddrM = 5'd8; RegWriteM = 1'b1; MemToRegM = 1'b1; RsE = 5'd8; settle();
    check("lu_next_stall", StallD, 0);
    check("lu_fwd_ae_m", ForwardAE, 1);
    check("lu_dcnt", DataStallCnt, 1);
    RegAddrW = 5'd8; RegWriteW = 1'b1; RtE = 5'd8; settle();
    check("fwd_m_over_w", ForwardBE, 1);
    RegWriteM = 1'b0; settle();
    check("fwd_w", ForwardAE, 2);
    RsE = 5'd0; RegAddrW = 5'd0; settle();
    check("fwd_zero_e", ForwardAE, 0);
    RtM = 5'd5; RegAddrW = 5'd5; settle();
    check("fwd_mem_w", ForwardM, 1);
    RegWriteW = 1'b0; settle();
    check("fwd_mem_nowr", ForwardM, 0);

    // usage 1 does not stall on a non-load E write
    idle(); RegAddrE = 5'd8; RegWriteE = 1'b1; RsD = 5'd8; RsUsageD = 2'd1; settle();
    check("u1_alu_nostall", StallD, 0);

    // branch-use
    idle(); RsD = 5'd9; RsUsageD = 2'd2; RegAddrE = 5'd9; RegWriteE = 1'b1; settle();
    check("bu_stall", StallD, 1);
    step();
    check("bu_dcnt", DataStallCnt, 2);
    RegAddrE = 5'd0; RegWriteE = 1'b0; RegAddrM = 5'd9; RegWriteM = 1'b1; settle();
    check("bu_next_stall", StallD, 0);
    check("bu_fwd_ad", ForwardAD, 1);
    MemToRegM = 1'b1; RtD = 5'd9; RtUsageD = 2'd2; RsUsageD = 2'd0; settle();
    check("bu_load_m_stall", StallD, 1);
    check("bu_fwd_bd", ForwardBD, 1);
    idle(); RsD = 5'd0; RsUsageD = 2'd2; RegAddrE = 5'd0; RegWriteE = 1'b1;
    RegAddrM = 5'd0; RegWriteM = 1'b1; settle();
    check("bu_r0_stall", StallD, 0);
    check("bu_r0_fwd", ForwardAD, 0);

    // clear before MDU
    idle(); ClearPerf = 1'b1; step(); ClearPerf = 1'b0;
    check("clr_dcnt", DataStallCnt, 0);

    // multiply, dependent MDU op held in D
    MDUUseD = 1'b1; StartMDUE = 1'b1; IsDivE = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      settle();
      check($sformatf("mul_stall_t%0d", i), StallD, 1);
      if (i > 0) check($sformatf("mul_busy_t%0d", i), MDUBusy, 1);
      step();
      StartMDUE = 1'b0;
    end
    settle();
    check("mul_stall_end", StallD, 0);
    check("mul_busy_end", MDUBusy, 0);
    check("mul_mcnt", MDUStallCnt, 6);
    check("mul_dcnt", DataStallCnt, 0);

    // divide, exception at t+3
    idle(); StartMDUE = 1'b1; IsDivE = 1'b1;
    step(); idle(); step(); step();
    ExcReqM = 1'b1; MDUUseD = 1'b1; settle();
    check("exc_flushd", FlushD, 1);
    check("exc_flushe", FlushE, 1);
    check("exc_flushm", FlushM, 1);
    check("exc_stalld", StallD, 0);
    check("exc_stallf", StallF, 0);
    step(); idle();
    for (int i = 0; i < 6; i++) step();
    check("div_busy_t10", MDUBusy, 1);
    check("div_mcnt_hold", MDUStallCnt, 6);
    step();
    check("div_busy_t11", MDUBusy, 0);

    // squashed start
    StartMDUE = 1'b1; IsDivE = 1'b1; ExcReqM = 1'b1;
    step(); idle(); settle();
    check("squash_busy", MDUBusy, 0);

    // saturation and clear
    load_use_rs8();
    for (int i = 0; i < 20; i++) step();
    check("sat_dcnt", DataStallCnt, 15);
    check("sat_mcnt", MDUStallCnt, 6);
    ClearPerf = 1'b1; step(); ClearPerf = 1'b0;
    check("clr_over_inc_d", DataStallCnt, 0);
    check("clr_over_inc_m", MDUStallCnt, 0);

    // both causes in one cycle, then async reset mid-divide
    idle(); load_use_rs8(); MDUUseD = 1'b1; StartMDUE = 1'b1; IsDivE = 1'b1;
    step(); idle();
    check("both_dcnt", DataStallCnt, 1);
    check("both_mcnt", MDUStallCnt, 1);
    check("both_busy", MDUBusy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", MDUBusy, 0);
    check("arst_dcnt", DataStallCnt, 0);
    check("arst_mcnt", MDUStallCnt, 0);
    reset = 1'b1;
    step();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
